// File: rtl/imem_loader.sv
// Serial program loader: receives a length byte, 4-byte big-endian words and an XOR checksum,
// writes each word to instruction memory and holds the CPU until the load completes.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start                   begin a load (taken in IDLE only)
//   byte_in, byte_valid     serial byte stream, transfers when byte_ready is also high
//   byte_ready              loader accepts a byte this cycle
//   wr_en, wr_addr, wr_data instruction memory write port, one strobe per word
//   cpu_hold                freezes PC and pipeline while not idle
//   done                    one-cycle completion pulse
//   err                     checksum mismatch, sticky until the next start
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [7:0]        acc;
    logic [ADDR_W-1:0] last;
    logic              xfer;

    assign xfer = byte_valid && byte_ready;

    // Outputs are registered alongside the state so each one always
    // reflects the state being entered on this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            acc        <= 8'd0;
            last       <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN;
                        err        <= 1'b0;
                        cnt        <= 2'd0;
                        wr_addr    <= '0;
                        acc        <= 8'd0;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        // Length byte encodes N-1, which is the last address.
                        last  <= ADDR_W'(byte_in);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wr_data <= {wr_data[23:0], byte_in};
                        acc     <= acc ^ byte_in;
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en      <= 1'b0;
                    byte_ready <= 1'b1;
                    // Compare before incrementing so a full-depth load
                    // stops at the top address instead of wrapping.
                    if (wr_addr == last) begin
                        state <= CHK;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        cnt     <= 2'd0;
                        state   <= DATA;
                    end
                end
                CHK: begin
                    if (xfer) begin
                        err        <= (byte_in != acc);
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
